// File: rtl/codec_audio_pkg.sv
// Shared constants, slot types and slot-classification helpers for the
// WM8731-class serial audio port.
package codec_audio_pkg;

    localparam int DEF_BCLKS_PER_FRAME = 125;
    localparam int DEF_LEFT_SLOTS      = 63;
    localparam int SLOT_W              = $clog2(DEF_BCLKS_PER_FRAME);

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        SLOT_LEFT,
        SLOT_RIGHT,
        SLOT_PAD
    } slot_kind_e;

    function automatic logic is_left(input slot_t slot, input slot_t left_slots);
        return slot < left_slots;
    endfunction

    // Left data occupies the first data_w slots, right data the first data_w
    // slots after the LRC edge; everything else is padding.
    function automatic slot_kind_e slot_kind(input slot_t slot,
                                             input slot_t left_slots,
                                             input slot_t data_w);
        if (slot < data_w)
            return SLOT_LEFT;
        if ((slot >= left_slots) && (slot < (left_slots + data_w)))
            return SLOT_RIGHT;
        return SLOT_PAD;
    endfunction

endpackage

// File: rtl/codec_i2s_clkgen.sv
// BCLK phase and slot timing for the audio port: one launch edge (BCLK fall)
// and one sample edge (BCLK rise) per slot, frames of BCLKS_PER_FRAME slots.
module codec_i2s_clkgen
    import codec_audio_pkg::*;
#(
    parameter int BCLKS_PER_FRAME = DEF_BCLKS_PER_FRAME,
    parameter int LEFT_SLOTS      = DEF_LEFT_SLOTS
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_en,
    output logic  o_bclk,
    output logic  o_lrc,
    output logic  o_launch,
    output logic  o_sample,
    output logic  o_frame_start,
    output slot_t o_slot
);

    localparam slot_t LAST_SLOT = slot_t'(BCLKS_PER_FRAME - 1);

    logic  r_phase;
    logic  r_run;
    logic  r_lrc;
    slot_t r_slot;

    logic  w_launch;
    logic  w_sample;
    slot_t w_next_slot;

    // The first enabled edge is a launch of slot 0, so a restart after an
    // abort always begins on a clean frame boundary.
    always_comb begin
        w_next_slot = '0;
        if (r_run && (r_slot != LAST_SLOT))
            w_next_slot = r_slot + slot_t'(1);
        w_launch = i_en && (!r_run || r_phase);
        w_sample = i_en && r_run && !r_phase;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_phase <= 1'b0;
            r_run   <= 1'b0;
            r_lrc   <= 1'b0;
            r_slot  <= '0;
        end else begin
            r_run   <= 1'b1;
            r_phase <= w_sample;
            if (w_launch) begin
                r_slot <= w_next_slot;
                r_lrc  <= is_left(w_next_slot, slot_t'(LEFT_SLOTS));
            end
        end
    end

    assign o_bclk        = r_phase;
    assign o_lrc         = r_lrc;
    assign o_launch      = w_launch;
    assign o_sample      = w_sample;
    assign o_frame_start = w_launch && (w_next_slot == '0);
    assign o_slot        = w_launch ? w_next_slot : r_slot;

endmodule

// File: rtl/codec_i2s_if.sv
// Master-mode left-justified audio port for a WM8731-class codec: serialises
// stereo DAC samples from a valid/ready source and captures stereo ADC words.
module codec_i2s_if
    import codec_audio_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int BCLKS_PER_FRAME = DEF_BCLKS_PER_FRAME,
    parameter int LEFT_SLOTS      = DEF_LEFT_SLOTS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_done,
    input  logic [DATA_W-1:0] i_dac_l,
    input  logic [DATA_W-1:0] i_dac_r,
    input  logic              i_dac_valid,
    output logic              o_dac_ready,
    output logic [DATA_W-1:0] o_adc_l,
    output logic [DATA_W-1:0] o_adc_r,
    output logic              o_adc_valid,
    output logic              o_underrun,
    output logic              o_bclk,
    output logic              o_daclrc,
    output logic              o_adclrc,
    output logic              o_dacdat,
    input  logic              i_adcdat
);

    localparam slot_t R_LAST = slot_t'(LEFT_SLOTS + DATA_W - 1);

    logic       w_lrc;
    logic       w_launch;
    logic       w_sample;
    logic       w_frame_start;
    slot_t      w_slot;
    slot_kind_e w_kind;

    logic [DATA_W-1:0] w_load_l;
    logic [DATA_W-1:0] w_load_r;

    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic              r_full;
    logic [DATA_W-1:0] r_sh_l;
    logic [DATA_W-1:0] r_sh_r;
    logic [DATA_W-1:0] r_cap_l;
    logic [DATA_W-1:0] r_cap_r;
    logic [DATA_W-1:0] r_adc_l;
    logic [DATA_W-1:0] r_adc_r;
    logic              r_adc_valid;
    logic              r_underrun;
    logic              r_dacdat;

    codec_i2s_clkgen #(
        .BCLKS_PER_FRAME (BCLKS_PER_FRAME),
        .LEFT_SLOTS      (LEFT_SLOTS)
    ) u_clkgen (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_cfg_done),
        .o_bclk        (o_bclk),
        .o_lrc         (w_lrc),
        .o_launch      (w_launch),
        .o_sample      (w_sample),
        .o_frame_start (w_frame_start),
        .o_slot        (w_slot)
    );

    assign w_kind   = slot_kind(w_slot, slot_t'(LEFT_SLOTS), slot_t'(DATA_W));
    assign w_load_l = r_full ? r_hold_l : '0;
    assign w_load_r = r_full ? r_hold_r : '0;

    // Frame start wins over a new transfer: while full the source sees
    // ready low, so a pair accepted at slot 0 waits for the next frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full   <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else if (w_frame_start && r_full) begin
            r_full <= 1'b0;
        end else if (i_dac_valid && !r_full) begin
            r_hold_l <= i_dac_l;
            r_hold_r <= i_dac_r;
            r_full   <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_l     <= '0;
            r_sh_r     <= '0;
            r_dacdat   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!i_cfg_done) begin
                r_dacdat <= 1'b0;
            end else if (w_frame_start) begin
                r_underrun <= !r_full;
                r_dacdat   <= w_load_l[DATA_W-1];
                r_sh_l     <= w_load_l << 1;
                r_sh_r     <= w_load_r;
            end else if (w_launch) begin
                case (w_kind)
                    SLOT_LEFT: begin
                        r_dacdat <= r_sh_l[DATA_W-1];
                        r_sh_l   <= r_sh_l << 1;
                    end
                    SLOT_RIGHT: begin
                        r_dacdat <= r_sh_r[DATA_W-1];
                        r_sh_r   <= r_sh_r << 1;
                    end
                    default: r_dacdat <= 1'b0;
                endcase
            end
        end
    end

    // The last right-channel bit is folded straight into the output word so
    // both channels publish together on the edge that samples it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cap_l     <= '0;
            r_cap_r     <= '0;
            r_adc_l     <= '0;
            r_adc_r     <= '0;
            r_adc_valid <= 1'b0;
        end else begin
            r_adc_valid <= 1'b0;
            if (w_sample) begin
                case (w_kind)
                    SLOT_LEFT: r_cap_l <= {r_cap_l[DATA_W-2:0], i_adcdat};
                    SLOT_RIGHT: begin
                        r_cap_r <= {r_cap_r[DATA_W-2:0], i_adcdat};
                        if (w_slot == R_LAST) begin
                            r_adc_l     <= r_cap_l;
                            r_adc_r     <= {r_cap_r[DATA_W-2:0], i_adcdat};
                            r_adc_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_dac_ready = !r_full;
    assign o_adc_l     = r_adc_l;
    assign o_adc_r     = r_adc_r;
    assign o_adc_valid = r_adc_valid;
    assign o_underrun  = r_underrun;
    assign o_daclrc    = w_lrc;
    assign o_adclrc    = w_lrc;
    assign o_dacdat    = r_dacdat;

endmodule

// File: tb/tb_codec_i2s_if.sv
// Randomised bench for codec_i2s_if: a frame-position reference model and a
// codec model driving i_adcdat, compared against the DUT every cycle.
module tb_codec_i2s_if;

    localparam int DATA_W    = 16;
    localparam int SLOTS     = 125;
    localparam int LEFT      = 63;
    localparam int FRAME_CYC = 2 * SLOTS;
    localparam int ADC_DONE  = 2 * (LEFT + DATA_W - 1) + 1;

    localparam int MODE_OFF    = 0;
    localparam int MODE_RANDOM = 1;
    localparam int MODE_ALWAYS = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfgDone = 1'b0;
    logic [DATA_W-1:0] dacL = '0;
    logic [DATA_W-1:0] dacR = '0;
    logic              dacValid = 1'b0;
    logic              adcDat = 1'b0;

    logic              dacReady;
    logic [DATA_W-1:0] adcL;
    logic [DATA_W-1:0] adcR;
    logic              adcValid;
    logic              underrun;
    logic              bclk;
    logic              dacLrc;
    logic              adcLrc;
    logic              dacDat;

    codec_i2s_if dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_done  (cfgDone),
        .i_dac_l     (dacL),
        .i_dac_r     (dacR),
        .i_dac_valid (dacValid),
        .o_dac_ready (dacReady),
        .o_adc_l     (adcL),
        .o_adc_r     (adcR),
        .o_adc_valid (adcValid),
        .o_underrun  (underrun),
        .o_bclk      (bclk),
        .o_daclrc    (dacLrc),
        .o_adclrc    (adcLrc),
        .o_dacdat    (dacDat),
        .i_adcdat    (adcDat)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: cycles since the port started, pending playback
    // pairs, the pair playing this frame and the pair the codec is sending.
    bit                running = 1'b0;
    int                cyc = 0;
    int                curSlot = 0;
    logic [31:0]       pending[$];
    logic [DATA_W-1:0] playL = '0, playR = '0;
    logic [DATA_W-1:0] codecL = '0, codecR = '0;
    bit                firstPair = 1'b1;

    logic              expBclk = 0, expLrc = 0, expDat = 0, expReady = 1;
    logic              expUnder = 0, expAdcValid = 0;
    logic [DATA_W-1:0] expAdcL = '0, expAdcR = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic bitFor(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                                    input int slot);
        if (slot < DATA_W)
            return l[DATA_W-1-slot];
        if (slot >= LEFT && slot < LEFT + DATA_W)
            return r[DATA_W-1-(slot-LEFT)];
        return 1'b0;
    endfunction

    // Advances the model across one rising clock edge using the driven inputs.
    task automatic modelEdge();
        bit accept;
        int pos;
        if (rst) begin
            running = 1'b0;
            pending.delete();
            {expBclk, expLrc, expDat, expUnder, expAdcValid} = '0;
            expAdcL  = '0;
            expAdcR  = '0;
            expReady = 1'b1;
            return;
        end
        accept      = dacValid && (pending.size() == 0);
        expUnder    = 1'b0;
        expAdcValid = 1'b0;
        if (!cfgDone) begin
            running = 1'b0;
            {expBclk, expLrc, expDat} = '0;
        end else begin
            cyc     = running ? cyc + 1 : 0;
            running = 1'b1;
            pos     = cyc % FRAME_CYC;
            curSlot = pos / 2;
            if (pos == 0) begin
                if (pending.size() > 0) begin
                    {playL, playR} = pending.pop_front();
                end else begin
                    playL    = '0;
                    playR    = '0;
                    expUnder = 1'b1;
                end
                if (firstPair) begin
                    codecL    = 16'h8001;
                    codecR    = 16'h7FFE;
                    firstPair = 1'b0;
                end else begin
                    codecL = DATA_W'($urandom);
                    codecR = DATA_W'($urandom);
                end
            end
            expBclk = (pos % 2) == 1;
            expLrc  = curSlot < LEFT;
            expDat  = bitFor(playL, playR, curSlot);
            if (pos == ADC_DONE) begin
                expAdcValid = 1'b1;
                expAdcL     = codecL;
                expAdcR     = codecR;
            end
        end
        if (accept)
            pending.push_back({dacL, dacR});
        expReady = pending.size() == 0;
    endtask

    // One clock cycle: drive inputs on the falling edge, predict, then check.
    task automatic applyStimulus(input logic rstV, input logic cfgV, input logic validV,
                                 input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        rst      = rstV;
        cfgDone  = cfgV;
        dacValid = validV;
        dacL     = l;
        dacR     = r;
        if (running && (curSlot < DATA_W || (curSlot >= LEFT && curSlot < LEFT + DATA_W)))
            adcDat = bitFor(codecL, codecR, curSlot);
        else
            adcDat = 1'($urandom);
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkOutput("bclk",      32'(bclk),     32'(expBclk));
        checkOutput("daclrc",    32'(dacLrc),   32'(expLrc));
        checkOutput("adclrc",    32'(adcLrc),   32'(expLrc));
        checkOutput("dacdat",    32'(dacDat),   32'(expDat));
        checkOutput("dac_ready", 32'(dacReady), 32'(expReady));
        checkOutput("underrun",  32'(underrun), 32'(expUnder));
        checkOutput("adc_valid", 32'(adcValid), 32'(expAdcValid));
        checkOutput("adc_l",     32'(adcL),     32'(expAdcL));
        checkOutput("adc_r",     32'(adcR),     32'(expAdcR));
    endtask

    task automatic runCycles(input int n, input int mode, input logic cfgV);
        logic v;
        for (int i = 0; i < n; i++) begin
            case (mode)
                MODE_RANDOM: v = ($urandom_range(0, 3) == 0);
                MODE_ALWAYS: v = 1'b1;
                default:     v = 1'b0;
            endcase
            applyStimulus(1'b0, cfgV, v, DATA_W'($urandom), DATA_W'($urandom));
        end
    endtask

    task automatic runToSlot(input int slot);
        int budget = 2 * FRAME_CYC;
        while (!(running && curSlot == slot) && budget > 0) begin
            runCycles(1, MODE_RANDOM, 1'b1);
            budget--;
        end
        checkOutput("slot_wait", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        runCycles(2, MODE_OFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hA5C3, 16'h0F01);
        runCycles(2 * FRAME_CYC, MODE_OFF, 1'b1);
        runCycles(4 * FRAME_CYC, MODE_RANDOM, 1'b1);
        runCycles(2 * FRAME_CYC, MODE_ALWAYS, 1'b1);
        runToSlot(40);
        runCycles(4, MODE_RANDOM, 1'b0);
        runToSlot(30);
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, DATA_W'($urandom), DATA_W'($urandom));
        runCycles(3, MODE_OFF, 1'b0);
        runCycles(FRAME_CYC + 20, MODE_RANDOM, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/codec_i2s_if.md
Name: codec_i2s_if

Overview:
- Serial audio data port for the WM8731-class codec. It sits downstream of the I2C configuration block and starts only after that block reports configuration done.
- The FPGA is the audio-port master: the codec is in slave mode, left-justified format, USB mode, and i_clk (12 MHz) doubles as MCLK.
- It generates BCLK/LRC, serialises stereo DAC samples from a valid/ready source, and deserialises ADC samples into a one-cycle valid stereo word.

Parameters:
- DATA_W, 16, bits per channel; must equal the codec IWL setting; legal range 16..32 (≤ LEFT_SLOTS-1).
- BCLKS_PER_FRAME, 125, BCLK periods per LRC frame (250 i_clk = 48 kHz at 12 MHz).
- LEFT_SLOTS, 63, slots with LRC high (left channel); the remaining slots are right.

Ports:
- i_clk  in  1  12 MHz system clock, also codec MCLK.
- i_rst  in  1  synchronous, active-high reset.
- i_cfg_done  in  1  codec configured; port runs only while high.
- i_dac_l  in  DATA_W  left playback sample, two's complement.
- i_dac_r  in  DATA_W  right playback sample.
- i_dac_valid  in  1  playback sample pair valid.
- o_dac_ready  out  1  holding register empty; transfer on valid&ready.
- o_adc_l  out  DATA_W  last captured left sample.
- o_adc_r  out  DATA_W  last captured right sample.
- o_adc_valid  out  1  one-cycle pulse; o_adc_l/r are updated.
- o_underrun  out  1  one-cycle pulse; frame started with no sample pending.
- o_bclk  out  1  codec BCLK = i_clk/2.
- o_daclrc  out  1  DAC LRC, 1 = left.
- o_adclrc  out  1  ADC LRC, identical to o_daclrc.
- o_dacdat  out  1  serial playback data.
- i_adcdat  in  1  serial capture data, driven by codec on BCLK fall.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous active-high. All state updates on posedge i_clk.
- Reset values: o_bclk=0, o_daclrc=o_adclrc=0, o_dacdat=0, o_dac_ready=1 (holding empty), o_adc_l=o_adc_r=0, o_adc_valid=0, o_underrun=0; phase, slot counter and shift registers = 0.
- Timing state:
  - phase bit: 0 = BCLK low, 1 = BCLK high; o_bclk is the registered phase.
  - slot counter: 0..BCLKS_PER_FRAME-1, wraps to 0.
- Idle (i_cfg_done=0): phase and slot are held at 0; o_bclk, o_*lrc and o_dacdat are 0. Holding register and o_adc_l/r keep their values. Dropping i_cfg_done mid-frame aborts on the next edge; no o_adc_valid for the partial frame.
- Launch edge (phase goes 1→0, or first edge after i_cfg_done rises):
  - starts slot s.
  - o_daclrc=o_adclrc = (s < LEFT_SLOTS).
  - o_dacdat = current bit of the channel shift register.
- Sample edge (phase goes 0→1): i_adcdat is shifted into the capture register for the current slot.
- DAC bit mapping:
  - slots 0..DATA_W-1 carry the left sample, MSB first.
  - slots LEFT_SLOTS..LEFT_SLOTS+DATA_W-1 carry the right sample, MSB first.
  - all other slots drive 0.
- Frame start (launch of slot 0):
  - If holding is full: the shift registers load the holding pair and holding clears (o_dac_ready=1 next cycle).
  - If holding is empty: the shift registers load zeros and o_underrun pulses for one cycle.
  - No bypass: a valid&ready transfer in that same cycle goes to holding and is used at the next frame.
- Holding register: loads on i_dac_valid&o_dac_ready; o_dac_ready=0 while full. i_dac_l/r are ignored when not ready.
- ADC capture: the same slot mapping as the DAC. On the cycle after the sample edge of slot LEFT_SLOTS+DATA_W-1:
  - o_adc_l/r update together;
  - o_adc_valid=1 for exactly one cycle, once per frame.
- Latency: the first o_bclk rise is 2 cycles after i_cfg_done is sampled high. A sample accepted before slot 0 appears on o_dacdat starting at that slot-0 launch.

Decomposition:
- Package codec_audio_pkg holds:
  - constants DEF_BCLKS_PER_FRAME=125 and DEF_LEFT_SLOTS=63;
  - slot counter width SLOT_W=$clog2(125)=7;
  - function is_left(slot).
- Sub-module codec_i2s_clkgen holds the phase bit and slot counter. It outputs o_bclk, lrc, launch strobe, sample strobe, frame_start and slot index. The parent holds the holding register, shift registers and capture logic.

Test Plan:
- Reset then i_cfg_done=1 -> o_bclk toggles every cycle; o_daclrc high for 126 cycles, low for 124; frame period 250 cycles.
- Load L=16'hA5C3, R=16'h0F01 before the first frame -> o_dacdat at slots 0..15 = 1010_0101_1100_0011 and slots 63..78 = 0000_1111_0000_0001; other slots 0; o_dac_ready=1 one cycle after slot-0 launch.
- Codec model drives i_adcdat on BCLK fall with L=16'h8001, R=16'h7FFE -> o_adc_valid pulses once per frame with o_adc_l=16'h8001, o_adc_r=16'h7FFE.
- No valid before a frame start -> o_underrun single pulse; o_dacdat all zero that frame. Previous sample not repeated.
- Two back-to-back valids -> first accepted; o_dac_ready low until the next slot-0 launch; second accepted only after.
- i_cfg_done dropped at slot 40, then i_rst mid-frame -> outputs idle next cycle; no o_adc_valid; after reset all outputs at reset values and o_dac_ready=1.
